// File: rtl/encoder_pkg.sv
// Shared types and helpers for the multi-turn encoder position tracker.
package encoder_pkg;

  localparam int ENC_POS_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    BLANK,
    ACQ,
    WAIT
  } tracker_state_t;

  // Shortest signed step between two angles; a half-turn (0x800) reads as -2048.
  function automatic logic signed [ENC_POS_W-1:0] enc_wrap_delta(
    input logic [ENC_POS_W-1:0] new_pos,
    input logic [ENC_POS_W-1:0] prev_pos
  );
    return new_pos - prev_pos;
  endfunction

endpackage

// File: rtl/encoder_unwrap.sv
// Unwraps successive 12-bit angles into a signed multi-turn position and per-sample delta.
module encoder_unwrap
  import encoder_pkg::*;
#(
  parameter int TURN_W = 20
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          accept,
  input  logic                          zero,
  input  logic                          rearm,
  input  logic [ENC_POS_W-1:0]          pos,
  output logic [TURN_W+ENC_POS_W-1:0]   o_pos,
  output logic [ENC_POS_W-1:0]          o_speed
);

  logic [ENC_POS_W-1:0]        prev;
  logic                        armed;
  logic signed [ENC_POS_W-1:0] delta;

  assign delta = enc_wrap_delta(pos, prev);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev    <= '0;
      armed   <= 1'b1;
      o_pos   <= '0;
      o_speed <= '0;
    end else begin
      if (accept) begin
        prev <= pos;
        if (armed) begin
          o_pos   <= {{TURN_W{1'b0}}, pos};
          o_speed <= '0;
          armed   <= 1'b0;
        end else begin
          o_pos   <= o_pos + {{TURN_W{delta[ENC_POS_W-1]}}, delta};
          o_speed <= delta;
        end
      end
      if (rearm) armed <= 1'b1;
      // Zeroing wins over an accept in the same cycle; prev is kept so later deltas stay relative.
      if (zero) o_pos <= '0;
    end
  end

endmodule

// File: rtl/encoder_pos_tracker.sv
// Periodically triggers the encoder reader, accepts its angle and tracks multi-turn position.
module encoder_pos_tracker
  import encoder_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int TIMEOUT       = 100000,
  parameter int TURN_W        = 20
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_zero,
  input  logic                        i_fault_clear,
  input  logic [ENC_POS_W-1:0]        i_enc_pos,
  input  logic                        i_enc_valid,
  output logic                        o_enc_start,
  output logic                        o_enc_clear,
  output logic [TURN_W+ENC_POS_W-1:0] o_pos,
  output logic [ENC_POS_W-1:0]        o_speed,
  output logic                        o_update,
  output logic                        o_pos_valid,
  output logic                        o_fault,
  output tracker_state_t              o_dbg_state
);

  localparam int PCNT_W = $clog2(SAMPLE_PERIOD);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PCNT_W-1:0] PERIOD_LAST  = PCNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT - 1);

  tracker_state_t    state, state_d;
  logic [PCNT_W-1:0] pcnt;
  logic [TCNT_W-1:0] tcnt;
  logic              accept, timeout, rearm;

  // Reader handshake: o_enc_start is a one-cycle request; the reader answers with a
  // one-cycle i_enc_valid carrying i_enc_pos. There is no backpressure, and valid is
  // only honoured in ACQ, after the blanking cycle that lets the reader drop stale valid.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    timeout = 1'b0;
    if (!i_enable) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:  state_d = TRIG;
        TRIG:  state_d = BLANK;
        BLANK: state_d = ACQ;
        ACQ: begin
          if (i_enc_valid) begin
            accept  = 1'b1;
            state_d = WAIT;
          end else if (tcnt == TIMEOUT_LAST) begin
            timeout = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT:    if (pcnt == PERIOD_LAST) state_d = TRIG;
        default: state_d = IDLE;
      endcase
    end
  end

  assign rearm       = timeout || !i_enable;
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      pcnt        <= '0;
      tcnt        <= '0;
      o_enc_start <= 1'b0;
      o_enc_clear <= 1'b0;
      o_update    <= 1'b0;
      o_pos_valid <= 1'b0;
      o_fault     <= 1'b0;
    end else begin
      state       <= state_d;
      o_enc_start <= i_enable && (state == TRIG);
      o_enc_clear <= timeout;
      o_update    <= accept;

      // Period counter counts cycles since TRIG and saturates, so a late WAIT retriggers at once.
      if (!i_enable || state == IDLE) pcnt <= '0;
      else if (state == TRIG)         pcnt <= PCNT_W'(1);
      else if (pcnt != PERIOD_LAST)   pcnt <= pcnt + PCNT_W'(1);

      if (i_enable && state == ACQ) tcnt <= tcnt + TCNT_W'(1);
      else                          tcnt <= '0;

      if (rearm)       o_pos_valid <= 1'b0;
      else if (accept) o_pos_valid <= 1'b1;

      if (timeout)            o_fault <= 1'b1;
      else if (i_fault_clear) o_fault <= 1'b0;
    end
  end

  encoder_unwrap #(
    .TURN_W(TURN_W)
  ) u_unwrap (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .accept  (accept),
    .zero    (i_zero),
    .rearm   (rearm),
    .pos     (i_enc_pos),
    .o_pos   (o_pos),
    .o_speed (o_speed)
  );

endmodule

// File: tb/tb_encoder_pos_tracker.sv
// Self-checking bench for encoder_pos_tracker: vector table plus hand sequences for timing corners.
module tb_encoder_pos_tracker;
  import encoder_pkg::*;

  localparam int SP     = 100;
  localparam int TO     = 50;
  localparam int TW     = 4;
  localparam int POS_W  = TW + 12;
  localparam int NVEC   = 22;

  typedef struct {
    logic [11:0]      angle;
    logic             zero;
    logic [POS_W-1:0] exp_pos;
    logic [11:0]      exp_speed;
  } vec_t;

  logic             clk, rst_n;
  logic             enable, zero, fault_clear, enc_valid;
  logic [11:0]      enc_pos;
  logic             enc_start, enc_clear, update, pos_valid, fault;
  logic [POS_W-1:0] pos;
  logic [11:0]      speed;
  tracker_state_t   dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [POS_W+11:0] exp_q[$];
  vec_t vec[NVEC];

  encoder_pos_tracker #(
    .SAMPLE_PERIOD(SP),
    .TIMEOUT      (TO),
    .TURN_W       (TW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_zero       (zero),
    .i_fault_clear(fault_clear),
    .i_enc_pos    (enc_pos),
    .i_enc_valid  (enc_valid),
    .o_enc_start  (enc_start),
    .o_enc_clear  (enc_clear),
    .o_pos        (pos),
    .o_speed      (speed),
    .o_update     (update),
    .o_pos_valid  (pos_valid),
    .o_fault      (fault),
    .o_dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each o_update against the oldest expected result
  always @(negedge clk) begin
    if (rst_n) begin
      if (enc_start && enc_clear) begin
        checks++;
        failures++;
        $display("FAIL start_clear_overlap: both high at cycle %0d", cyc);
      end
      if (update) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update: pos=0x%0h speed=0x%0h cycle %0d", pos, speed, cyc);
        end else begin
          logic [POS_W+11:0] e;
          e = exp_q.pop_front();
          chk("upd_pos", 32'(pos), 32'(e[POS_W+11:12]));
          chk("upd_speed", 32'(speed), 32'(e[11:0]));
          chk("upd_pos_valid", 32'(pos_valid), 32'd1);
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_start(output int s);
    s = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (enc_start) begin
        s = cyc;
        break;
      end
    end
    chk("start_seen", 32'(s >= 0), 32'd1);
  endtask

  task automatic drive_sample(input logic [11:0] a, input logic z,
                              input logic [POS_W-1:0] ep, input logic [11:0] es);
    tick();
    enc_valid = 1'b1;
    enc_pos   = a;
    zero      = z;
    exp_q.push_back({ep, es});
    tick();
    enc_valid = 1'b0;
    zero      = 1'b0;
  endtask

  task automatic do_sample(input logic [11:0] a, input logic z,
                           input logic [POS_W-1:0] ep, input logic [11:0] es);
    int s;
    wait_start(s);
    drive_sample(a, z, ep, es);
  endtask

  task automatic silent_timeout(input logic clr_same, input logic [POS_W-1:0] held);
    int s;
    int seen;
    wait_start(s);
    seen = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (clr_same) fault_clear = (cyc == s + TO);
      else          fault_clear = 1'b0;
      if (enc_clear) begin
        seen = cyc;
        break;
      end
    end
    fault_clear = 1'b0;
    chk("clear_cycle", 32'(seen), 32'(s + 1 + TO));
    chk("clear_no_start", 32'(enc_start), 32'd0);
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_pos_valid", 32'(pos_valid), 32'd0);
    chk("timeout_pos_held", 32'(pos), 32'(held));
    tick();
    chk("clear_one_cycle", 32'(enc_clear), 32'd0);
  endtask

  initial begin
    int s1, s2;
    logic [11:0]      ang;
    logic [POS_W-1:0] acc;
    logic             start_seen_off;

    // Vector table: wraps, half turn and accumulator wrap into the sign bit
    vec[0] = '{12'h010, 1'b0, 16'h1010, 12'h020};
    vec[1] = '{12'hFF0, 1'b0, 16'h0FF0, 12'hFE0};
    vec[2] = '{12'h000, 1'b0, 16'h1000, 12'h010};
    vec[3] = '{12'h800, 1'b0, 16'h0800, 12'h800};
    ang = 12'h800;
    acc = 16'h0800;
    for (int k = 0; k < 15; k++) begin
      ang = ang + 12'h7F0;
      acc = acc + 16'h07F0;
      vec[4 + k] = '{ang, 1'b0, acc, 12'h7F0};
    end
    vec[19] = '{12'hFF0, 1'b0, 16'h7FF0, 12'h0E0};
    vec[20] = '{12'h000, 1'b0, 16'h8000, 12'h010};
    vec[21] = '{12'h010, 1'b0, 16'h8010, 12'h010};

    rst_n = 1'b0; enable = 1'b0; zero = 1'b0; fault_clear = 1'b0;
    enc_valid = 1'b0; enc_pos = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_speed", 32'(speed), 32'd0);
    chk("rst_flags", {27'd0, enc_start, enc_clear, update, pos_valid, fault}, 32'd0);

    // First trigger timing, armed first sample and period spacing
    enable = 1'b1;
    tick();
    chk("start_not_early", 32'(enc_start), 32'd0);
    tick();
    chk("start_at_2", 32'(enc_start), 32'd1);
    s1 = cyc;
    drive_sample(12'h100, 1'b0, 16'h0100, 12'h000);
    wait_start(s2);
    chk("period_spacing", 32'(s2 - s1), 32'(SP));
    drive_sample(12'h180, 1'b0, 16'h0180, 12'h080);

    // Drop enable in ACQ; a later result must be ignored
    wait_start(s1);
    tick();
    enable = 1'b0;
    tick();
    enc_valid = 1'b1;
    enc_pos   = 12'h555;
    tick();
    enc_valid = 1'b0;
    start_seen_off = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      start_seen_off = start_seen_off | enc_start;
    end
    chk("disabled_no_start", 32'(start_seen_off), 32'd0);
    chk("disabled_pos_valid", 32'(pos_valid), 32'd0);
    chk("disabled_pos_held", 32'(pos), 32'h0180);
    chk("disabled_speed_held", 32'(speed), 32'h080);
    enable = 1'b1;
    do_sample(12'hFF0, 1'b0, 16'h0FF0, 12'h000);

    for (int i = 0; i < NVEC; i++)
      do_sample(vec[i].angle, vec[i].zero, vec[i].exp_pos, vec[i].exp_speed);
    chk("pos_negative", 32'($signed(pos) < 0), 32'd1);

    // Reader silent: timeout, re-arm, sticky fault, clear vs new timeout
    silent_timeout(1'b0, 16'h8010);
    do_sample(12'h200, 1'b0, 16'h0200, 12'h000);
    chk("fault_sticky", 32'(fault), 32'd1);
    silent_timeout(1'b1, 16'h0200);
    do_sample(12'h210, 1'b0, 16'h0210, 12'h000);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    chk("fault_cleared", 32'(fault), 32'd0);

    // Zero coinciding with an accept, then relative delta afterwards
    do_sample(12'h215, 1'b1, 16'h0000, 12'h005);
    do_sample(12'h218, 1'b0, 16'h0003, 12'h003);

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_pos_tracker.md
# encoder_pos_tracker

Multi-turn position tracker sitting directly downstream of the PWM encoder reader. It periodically triggers the reader, accepts each 12-bit absolute angle, and unwraps successive samples across the 0/4095 boundary. It accumulates a signed multi-turn position and reports the per-period angle delta as a speed estimate for the motor control loop.

## Interface
Parameters:
- SAMPLE_PERIOD, 50000 — clock cycles between successive triggers; must be ≥ 4.
- TIMEOUT, 100000 — maximum cycles spent waiting for a reader result.
- TURN_W, 20 — turn-count width; position width is TURN_W+12.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  level; tracking runs while high.
- i_zero  in  1  pulse; sets accumulated position to 0.
- i_fault_clear  in  1  pulse; clears o_fault.
- i_enc_pos  in  12  angle from reader.
- i_enc_valid  in  1  reader result valid.
- o_enc_start  out  1  one-cycle trigger to reader.
- o_enc_clear  out  1  one-cycle clear/recalibrate request to reader.
- o_pos  out  TURN_W+12  signed accumulated position, in LSB of angle.
- o_speed  out  12  signed delta of last update, in LSB per period.
- o_update  out  1  one-cycle pulse when o_pos/o_speed are updated.
- o_pos_valid  out  1  level; tracking is established.
- o_fault  out  1  sticky timeout flag.

## Operation
- All outputs reset to 0; FSM resets to IDLE; armed flag reset to 1.
- FSM states:
  - IDLE: on i_enable, go to TRIG.
  - TRIG: assert o_enc_start for 1 cycle, restart period counter, go to BLANK.
  - BLANK: 1 cycle; i_enc_valid is ignored in TRIG and BLANK, since the reader drops valid within one cycle of start. Go to ACQ.
  - ACQ: first cycle with i_enc_valid=1 accepts i_enc_pos, then go to WAIT. If the timeout counter reaches TIMEOUT-1, go to WAIT and apply the fault actions below.
  - WAIT: when the period counter reaches SAMPLE_PERIOD-1, go to TRIG. If the period has already elapsed on entry, go to TRIG on the next cycle; no backlog is kept.
- Accept, armed=1: o_pos ← zero-extended i_enc_pos, o_speed ← 0, o_pos_valid ← 1, armed ← 0.
- Accept, armed=0:
  - d = (i_enc_pos − prev) mod 4096, interpreted as 12-bit two's complement, giving range −2048..+2047.
  - A difference of exactly 2048 is taken as −2048.
  - o_pos ← o_pos + sign-extended d, wrapping mod 2^(TURN_W+12).
  - o_speed ← d.
- Every accept: prev ← i_enc_pos, o_update pulses.
- Timeout actions: o_enc_clear pulses 1 cycle, o_fault ← 1, o_pos_valid ← 0, armed ← 1. o_pos and o_speed hold their values.
- i_zero: o_pos ← 0 next cycle. prev is kept, so subsequent deltas are relative. When i_zero coincides with an accept:
  - o_pos ← 0, which takes priority.
  - o_speed ← d.
  - o_update pulses.
- i_fault_clear clears o_fault. A new timeout in the same cycle wins, leaving o_fault at 1.
- i_enable low, any state: IDLE next cycle; o_pos_valid ← 0; armed ← 1; counters cleared; o_pos and o_speed held. A result arriving later is ignored.

## Timing
- o_enc_start is high exactly 2 cycles after the cycle in which i_enable is first sampled high: cycle 1 is the IDLE→TRIG transition, cycle 2 is the TRIG output.
- Accept latency is 1 cycle. i_enc_valid sampled high in cycle N gives updated o_pos, o_speed, o_update=1 and o_pos_valid in cycle N+1.
- Trigger spacing:
  - Exactly SAMPLE_PERIOD cycles when the acquisition completes in time.
  - Otherwise, accept cycle + 2.
- Timeout: o_enc_clear is asserted TIMEOUT cycles after ACQ entry if no valid arrives.
- o_enc_start and o_enc_clear are never high in the same cycle.

## Structure
- Package encoder_pkg holds:
  - ENC_POS_W = 12.
  - The tracker state typedef enum {IDLE, TRIG, BLANK, ACQ, WAIT}.
  - Function enc_wrap_delta(new, prev), returning a signed 12-bit value.
- Sub-module encoder_unwrap holds prev, the armed flag and the accumulator. Interface: accept, zero, rearm, pos in; o_pos and o_speed out.
- The FSM, period counter and timeout counter live in the top.

## Test plan
Bench parameters: SAMPLE_PERIOD=100, TIMEOUT=50, TURN_W=4.
1. Enable; reader returns 0x100 → o_enc_start pulses 2 cycles after enable; o_pos=0x0100, o_speed=0, o_pos_valid=1; next o_enc_start follows 100 cycles after the first.
2. Forward wrap: samples 0xFF0 then 0x010 → o_speed=+32, o_pos 0x0FF0→0x1010. Reverse wrap: 0x010→0xFF0 → o_speed=−32, o_pos back to 0x0FF0.
3. Half turn: 0x000→0x800 → o_speed=−2048. Accumulator: starting from o_pos=0x7FF0 (turn 7), repeated +16 steps wrap to 0x8000, which is negative.
4. Reader silent → 50 cycles after ACQ entry, o_enc_clear pulses, o_fault=1, o_pos_valid=0. The next valid sample of 0x200 gives o_pos=0x0200 and o_speed=0. i_fault_clear then clears o_fault.
5. i_zero on the same cycle as a valid with d=+5 → o_pos=0, o_speed=5, o_update=1. The next sample with d=+3 gives o_pos=3.
6. Drop i_enable in ACQ, then raise valid → no o_update, o_pos_valid=0, o_pos held. Re-enable → new trigger, and the next sample re-arms.
